// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: valid/ready PC offer, redirects, traps, halt/resume.
// Optional performance counters are built when PC_PERF_EN is defined.
module pc_sequencer #(
  parameter int unsigned        PC_W        = 64,
  parameter int unsigned        INSTR_BYTES = 4,
  parameter logic [PC_W-1:0]    RESET_VEC   = '0,
  parameter logic [PC_W-1:0]    TRAP_VEC    = PC_W'('h100)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [PC_W-1:0] pc_o,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [PC_W-1:0] epc_o,
  output logic [1:0]      cause_o,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     stall_cnt_o
);

  localparam int unsigned     CNT_W      = 32;
  localparam int unsigned     CAUSE_W    = 2;
  localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INSTR_BYTES - 1);

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_EXT  = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_MIS  = CAUSE_W'(2);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      epc_q, epc_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 valid_q, valid_d;

  logic fire;
  logic mis;

  assign fire = valid_q & fetch_ready_i;
  assign mis  = redirect_i & ((redirect_pc_i & ALIGN_MASK) != '0);

  // Next-state: trap beats misaligned redirect beats redirect beats sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HALTED: begin
        if (trap_i) begin
          pc_d    = TRAP_VEC;
          epc_d   = pc_q;
          cause_d = CAUSE_EXT;
          state_d = ST_RUN;
        end else if (mis) begin
          pc_d    = TRAP_VEC;
          epc_d   = redirect_pc_i;
          cause_d = CAUSE_MIS;
          state_d = ST_RUN;
        end else begin
          if (redirect_i) begin
            pc_d = redirect_pc_i;
          end else if (fire) begin
            pc_d = pc_q + PC_INC;
          end
          if (state_q == ST_RUN) begin
            if (halt_i) state_d = ST_HALTED;
          end else if (resume_i) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      valid_q <= valid_d;
    end
  end

  assign fetch_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;

`ifdef PC_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Free-running wrap-around counters of accepted fetches and back-pressured cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fire) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    if (valid_q & ~fetch_ready_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = CNT_W'(0);
  assign stall_cnt_o = CNT_W'(0);
`endif

endmodule
